// File: rtl/param_arb_mux_pkg.sv
// rtl/param_arb_mux_pkg.sv - shared mode constants and width helper for the arbitrated stream mux
package arb_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_arb_mux_if.sv
// rtl/param_arb_mux_if.sv - producer-side channels and consumer-side output of the stream mux
interface param_arb_mux_if #(
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SEL_WIDTH-1:0]         out_ch;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/param_arb_mux_rr_arbiter.sv
// rtl/param_arb_mux_rr_arbiter.sv - combinational round-robin arbiter, priority starts at i_ptr
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM_CH-1:0]    i_req,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    output logic [NUM_CH-1:0]    o_grant,
    output logic [SEL_WIDTH-1:0] o_grant_idx,
    output logic                 o_any_grant
);
    localparam int OFF_W = clog2(NUM_CH);
    localparam int SUM_W = SEL_WIDTH + 1;

    logic [2*NUM_CH-1:0] w_req2;
    logic [NUM_CH-1:0]   w_rot;
    logic [OFF_W-1:0]    w_off;
    logic [SUM_W-1:0]    w_sum;

    // Doubling the request vector turns the wrap-around scan into a plain shift.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = NUM_CH'(w_req2 >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = OFF_W'(j);
            end
        end
    end

    assign w_sum       = {1'b0, i_ptr} + SUM_W'(w_off);
    assign o_grant_idx = (w_sum >= SUM_W'(NUM_CH)) ? SEL_WIDTH'(w_sum - SUM_W'(NUM_CH))
                                                   : SEL_WIDTH'(w_sum);
    assign o_any_grant = |i_req;
    assign o_grant     = o_any_grant ? (NUM_CH'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/param_arb_mux.sv
// rtl/param_arb_mux.sv - registered N-channel stream mux with manual or round-robin selection
module param_arb_mux
    import arb_mux_pkg::*;
#(
    parameter int SEL_WIDTH  = 2,
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic                 sel_err,
    param_arb_mux_if.slave       bus
);
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_WIDTH-1:0]  r_out_ch;
    logic [SEL_WIDTH-1:0]  r_ptr;
    logic                  r_sel_err;

    logic                  w_can_load;
    logic                  w_sel_ok;
    logic                  w_any_grant;
    logic                  w_rr_any;
    logic                  w_xfer;
    logic [NUM_CH-1:0]     w_man_grant;
    logic [NUM_CH-1:0]     w_rr_grant;
    logic [NUM_CH-1:0]     w_grant;
    logic [NUM_CH-1:0]     w_ready;
    logic [SEL_WIDTH-1:0]  w_rr_idx;
    logic [SEL_WIDTH-1:0]  w_grant_idx;
    logic [SEL_WIDTH-1:0]  w_ptr_next;
    logic [DATA_WIDTH-1:0] w_data;

    rr_arbiter #(
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_arbiter (
        .i_req       (bus.in_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_rr_grant),
        .o_grant_idx (w_rr_idx),
        .o_any_grant (w_rr_any)
    );

    assign w_can_load = !r_out_valid || bus.out_ready;
    assign w_sel_ok   = {1'b0, sel} < (SEL_WIDTH + 1)'(NUM_CH);
    // An out-of-range sel shifts the one-hot off the end, so it can never grant.
    assign w_man_grant = bus.in_valid & (NUM_CH'(1) << sel);

    assign w_grant     = (mode == MODE_RR) ? w_rr_grant : w_man_grant;
    assign w_grant_idx = (mode == MODE_RR) ? w_rr_idx : sel;
    assign w_any_grant = (mode == MODE_RR) ? w_rr_any : |w_man_grant;

    // Holding in_ready low during reset keeps producers from seeing a phantom accept.
    assign w_ready      = (rst_n && w_can_load && w_any_grant) ? w_grant : '0;
    assign w_xfer       = |w_ready;
    assign bus.in_ready = w_ready;

    assign w_ptr_next = (w_grant_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant[k]) begin
                w_data = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_grant_idx;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && mode == MODE_RR) begin
                r_ptr <= w_ptr_next;
            end
            if (mode == MODE_MANUAL && !w_sel_ok && |bus.in_valid) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign sel_err       = r_sel_err;

endmodule
